sm_step_driver: RTL and testbench

Downstream stage of the stepper tracking chain: consumes the step-request pulse train (`drv_step`), direction (`drv_dir`) and motor enable (`drv_enable_SM`) from the step pulse generator. It produces electrically safe STEP/DIR/ENA signals for the external stepper power driver by enforcing enable-setup, direction-setup and minimum high/low pulse widths. It also maintains the absolute motor position counter, enforces hardware limit switches, and reports dropped (overrun) requests.

---
 rtl/sm_drv_pkg.sv | 31 +++
 rtl/sm_cycle_timer.sv | 27 ++
 rtl/sm_step_driver.sv | 179 +++++++++++++++++
 tb/tb_sm_step_driver.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sm_drv_pkg.sv
// Shared FSM state type, default 50 MHz timing constants and sizing helpers
// for the stepper power-driver interface.
package sm_drv_pkg;

  typedef enum logic [2:0] {
    ST_DISABLED = 3'd0,
    ST_ENA_WAIT = 3'd1,
    ST_IDLE     = 3'd2,
    ST_DIR_WAIT = 3'd3,
    ST_STEP_HI  = 3'd4,
    ST_STEP_LO  = 3'd5
  } sm_state_t;

  // Defaults give 2 us / 2 us / 5 us / 10 us at a 50 MHz clock.
  localparam int unsigned DEF_STEP_HIGH_CYC = 100;
  localparam int unsigned DEF_STEP_LOW_CYC  = 100;
  localparam int unsigned DEF_DIR_SETUP_CYC = 250;
  localparam int unsigned DEF_ENA_SETUP_CYC = 500;
  localparam int unsigned DEF_POS_W         = 32;
  localparam int unsigned OVR_W             = 16;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Bits needed to hold values 0 .. n-1 (never less than one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sm_cycle_timer.sv
// Loadable down-counter used by the step driver FSM to time each state;
// done is high while the count sits at zero.
module sm_cycle_timer #(
  parameter int unsigned CNT_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  output logic             done
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= value;
    end else if (r_count != '0) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign done = (r_count == '0);

endmodule

// File: rtl/sm_step_driver.sv
// Shapes step requests into safe STEP/DIR/ENA timing for the external power
// driver, tracks absolute position, enforces limit switches, counts overruns.
module sm_step_driver
  import sm_drv_pkg::*;
#(
  parameter int unsigned STEP_HIGH_CYC = DEF_STEP_HIGH_CYC,
  parameter int unsigned STEP_LOW_CYC  = DEF_STEP_LOW_CYC,
  parameter int unsigned DIR_SETUP_CYC = DEF_DIR_SETUP_CYC,
  parameter int unsigned ENA_SETUP_CYC = DEF_ENA_SETUP_CYC,
  parameter int unsigned POS_W         = DEF_POS_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    drv_step,
  input  logic                    drv_dir,
  input  logic                    drv_enable_SM,
  input  logic                    lim_fwd,
  input  logic                    lim_rev,
  input  logic                    pos_clr,
  output logic                    sm_step,
  output logic                    sm_dir,
  output logic                    sm_ena,
  output logic signed [POS_W-1:0] position,
  output logic                    busy,
  output logic                    limit_hit,
  output logic [OVR_W-1:0]        overrun_cnt
);

  localparam int unsigned MAX_CYC = max_u(max_u(STEP_HIGH_CYC, STEP_LOW_CYC),
                                          max_u(DIR_SETUP_CYC, ENA_SETUP_CYC));
  localparam int unsigned CNT_W   = cnt_width(MAX_CYC);

  sm_state_t r_state;
  sm_state_t w_state_nxt;

  logic                    r_step_d;
  logic                    r_pend;
  logic                    r_pend_dir;
  logic                    r_sm_step;
  logic                    r_sm_dir;
  logic                    r_sm_ena;
  logic                    r_busy;
  logic                    r_limit_hit;
  logic signed [POS_W-1:0] r_pos;
  logic [OVR_W-1:0]        r_ovr;

  logic             w_rise;
  logic             w_lim_block;
  logic             w_limit_drop;
  logic             w_step_done;
  logic             w_consume;
  logic             w_tmr_load;
  logic             w_tmr_done;
  logic [CNT_W-1:0] w_tmr_val;

  assign w_rise      = drv_step & ~r_step_d;
  assign w_lim_block = r_pend_dir ? lim_fwd : lim_rev;

  // Next-state decision; an enable drop overrides everything.
  always_comb begin
    w_state_nxt  = r_state;
    w_limit_drop = 1'b0;
    w_step_done  = 1'b0;
    if (!drv_enable_SM) begin
      w_state_nxt = ST_DISABLED;
    end else begin
      case (r_state)
        ST_DISABLED: w_state_nxt = ST_ENA_WAIT;
        ST_ENA_WAIT: if (w_tmr_done) w_state_nxt = ST_IDLE;
        ST_IDLE: begin
          if (r_pend) begin
            if (w_lim_block) begin
              w_limit_drop = 1'b1;
            end else if (r_pend_dir != r_sm_dir) begin
              w_state_nxt = ST_DIR_WAIT;
            end else begin
              w_state_nxt = ST_STEP_HI;
            end
          end
        end
        ST_DIR_WAIT: if (w_tmr_done) w_state_nxt = ST_STEP_HI;
        ST_STEP_HI: begin
          if (w_tmr_done) begin
            w_state_nxt = ST_STEP_LO;
            w_step_done = 1'b1;
          end
        end
        ST_STEP_LO: if (w_tmr_done) w_state_nxt = ST_IDLE;
        default:    w_state_nxt = ST_DISABLED;
      endcase
    end
  end

  // Timer is reloaded with N-1 on entry so the state lasts exactly N cycles.
  always_comb begin
    w_tmr_val = '0;
    case (w_state_nxt)
      ST_ENA_WAIT: w_tmr_val = CNT_W'(ENA_SETUP_CYC - 1);
      ST_DIR_WAIT: w_tmr_val = CNT_W'(DIR_SETUP_CYC - 1);
      ST_STEP_HI:  w_tmr_val = CNT_W'(STEP_HIGH_CYC - 1);
      ST_STEP_LO:  w_tmr_val = CNT_W'(STEP_LOW_CYC - 1);
      default:     w_tmr_val = '0;
    endcase
  end

  assign w_tmr_load = (w_state_nxt != r_state);
  assign w_consume  = w_limit_drop |
                      ((w_state_nxt == ST_STEP_HI) && (r_state != ST_STEP_HI));

  sm_cycle_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (w_tmr_load),
    .value (w_tmr_val),
    .done  (w_tmr_done)
  );

  // One-deep request latch; a new edge in the consuming cycle is accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_step_d   <= 1'b0;
      r_pend     <= 1'b0;
      r_pend_dir <= 1'b0;
      r_ovr      <= '0;
    end else begin
      r_step_d <= drv_step;
      if (!drv_enable_SM || (r_state == ST_DISABLED)) begin
        r_pend <= 1'b0;
      end else if (w_rise) begin
        if (r_pend && !w_consume) begin
          if (r_ovr != '1) r_ovr <= r_ovr + OVR_W'(1);
        end else begin
          r_pend     <= 1'b1;
          r_pend_dir <= drv_dir;
        end
      end else if (w_consume) begin
        r_pend <= 1'b0;
      end
    end
  end

  // State register and registered driver outputs, all derived from next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_DISABLED;
      r_sm_step   <= 1'b0;
      r_sm_dir    <= 1'b0;
      r_sm_ena    <= 1'b0;
      r_busy      <= 1'b0;
      r_limit_hit <= 1'b0;
      r_pos       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_sm_step   <= (w_state_nxt == ST_STEP_HI);
      r_sm_ena    <= (w_state_nxt != ST_DISABLED);
      r_busy      <= (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_DISABLED);
      r_limit_hit <= w_limit_drop;
      if ((r_state == ST_IDLE) && (w_state_nxt == ST_DIR_WAIT)) begin
        r_sm_dir <= r_pend_dir;
      end
      if (pos_clr) begin
        r_pos <= '0;
      end else if (w_step_done) begin
        r_pos <= r_sm_dir ? (r_pos + POS_W'(1)) : (r_pos - POS_W'(1));
      end
    end
  end

  assign sm_step     = r_sm_step;
  assign sm_dir      = r_sm_dir;
  assign sm_ena      = r_sm_ena;
  assign position    = r_pos;
  assign busy        = r_busy;
  assign limit_hit   = r_limit_hit;
  assign overrun_cnt = r_ovr;

endmodule

// File: tb/tb_sm_step_driver.sv
// Directed self-checking bench for sm_step_driver with default timing and an
// 8-bit position counter so wrap-around is reachable.
module tb_sm_step_driver;

  logic              clk = 1'b0;
  logic              rst;
  logic              drv_step;
  logic              drv_dir;
  logic              drv_enable_SM;
  logic              lim_fwd;
  logic              lim_rev;
  logic              pos_clr;
  logic              sm_step;
  logic              sm_dir;
  logic              sm_ena;
  logic signed [7:0] position;
  logic              busy;
  logic              limit_hit;
  logic [15:0]       overrun_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  sm_step_driver #(
    .STEP_HIGH_CYC (100),
    .STEP_LOW_CYC  (100),
    .DIR_SETUP_CYC (250),
    .ENA_SETUP_CYC (500),
    .POS_W         (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .drv_step      (drv_step),
    .drv_dir       (drv_dir),
    .drv_enable_SM (drv_enable_SM),
    .lim_fwd       (lim_fwd),
    .lim_rev       (lim_rev),
    .pos_clr       (pos_clr),
    .sm_step       (sm_step),
    .sm_dir        (sm_dir),
    .sm_ena        (sm_ena),
    .position      (position),
    .busy          (busy),
    .limit_hit     (limit_hit),
    .overrun_cnt   (overrun_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive a one-cycle request; returns just after the edge that samples it.
  task automatic pulse_step(input logic dir);
    drv_dir  = dir;
    drv_step = 1'b1;
    tick(1);
    drv_step = 1'b0;
  endtask

  task automatic wait_rise(input int max, output int t);
    t = 0;
    while (sm_step !== 1'b1 && t < max) begin
      tick(1);
      t++;
    end
  endtask

  task automatic wait_fall(input int max, output int t);
    t = 0;
    while (sm_step !== 1'b0 && t < max) begin
      tick(1);
      t++;
    end
  endtask

  task automatic wait_idle(input int max, output int t);
    t = 0;
    while (busy !== 1'b0 && t < max) begin
      tick(1);
      t++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; drv_step = 1'b0; drv_dir = 1'b0; drv_enable_SM = 1'b0;
    lim_fwd = 1'b0; lim_rev = 1'b0; pos_clr = 1'b0;
    tick(3);
    n_checks++; if (sm_step !== 1'b0) begin n_fail++; $display("FAIL rst_step: got %b want 0", sm_step); end
    n_checks++; if (sm_dir !== 1'b0) begin n_fail++; $display("FAIL rst_dir: got %b want 0", sm_dir); end
    n_checks++; if (sm_ena !== 1'b0) begin n_fail++; $display("FAIL rst_ena: got %b want 0", sm_ena); end
    n_checks++; if (position !== 8'sd0) begin n_fail++; $display("FAIL rst_pos: got %0d want 0", position); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_checks++; if (limit_hit !== 1'b0) begin n_fail++; $display("FAIL rst_limit: got %b want 0", limit_hit); end
    n_checks++; if (overrun_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_ovr: got %0d want 0", overrun_cnt); end
    rst = 1'b1;
    tick(2);
    n_checks++; if (sm_ena !== 1'b0) begin n_fail++; $display("FAIL disabled_ena: got %b want 0", sm_ena); end
  endtask

  task automatic test_enable_single();
    int t;
    drv_enable_SM = 1'b1;
    tick(1);
    n_checks++; if (sm_ena !== 1'b1) begin n_fail++; $display("FAIL ena_rise: got %b want 1", sm_ena); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ena_busy: got %b want 1", busy); end
    tick(599);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ena_idle: got busy %b want 0", busy); end
    pulse_step(1'b0);
    n_checks++; if (sm_step !== 1'b0) begin n_fail++; $display("FAIL step_latency1: got %b want 0", sm_step); end
    tick(1);
    n_checks++; if (sm_step !== 1'b1) begin n_fail++; $display("FAIL step_latency2: got %b want 1", sm_step); end
    wait_fall(300, t);
    n_checks++; if (t != 100) begin n_fail++; $display("FAIL step_high_width: got %0d want 100", t); end
    n_checks++; if (position !== -8'sd1) begin n_fail++; $display("FAIL single_pos: got %0d want -1", position); end
  endtask

  task automatic test_reversal();
    int t;
    wait_idle(400, t);
    pulse_step(1'b1);
    n_checks++; if (sm_dir !== 1'b0) begin n_fail++; $display("FAIL dir_hold: got %b want 0", sm_dir); end
    tick(1);
    n_checks++; if (sm_dir !== 1'b1) begin n_fail++; $display("FAIL dir_fwd_toggle: got %b want 1", sm_dir); end
    n_checks++; if (sm_step !== 1'b0) begin n_fail++; $display("FAIL dir_setup_step: got %b want 0", sm_step); end
    wait_rise(400, t);
    n_checks++; if (t != 250) begin n_fail++; $display("FAIL dir_setup_fwd: got %0d want 250", t); end
    wait_fall(300, t);
    n_checks++; if (position !== 8'sd0) begin n_fail++; $display("FAIL fwd1_pos: got %0d want 0", position); end
    pulse_step(1'b1);
    wait_rise(400, t);
    wait_fall(300, t);
    n_checks++; if (position !== 8'sd1) begin n_fail++; $display("FAIL fwd2_pos: got %0d want 1", position); end
    wait_idle(400, t);
    pulse_step(1'b0);
    tick(1);
    n_checks++; if (sm_dir !== 1'b0) begin n_fail++; $display("FAIL dir_rev_toggle: got %b want 0", sm_dir); end
    wait_rise(400, t);
    n_checks++; if (t != 250) begin n_fail++; $display("FAIL dir_setup_rev: got %0d want 250", t); end
    wait_fall(300, t);
    n_checks++; if (position !== 8'sd0) begin n_fail++; $display("FAIL rev_pos: got %0d want 0", position); end
  endtask

  task automatic test_back_to_back();
    int t;
    int rises;
    int first;
    int second;
    logic prev;
    wait_idle(400, t);
    rises = 0; first = -1; second = -1; prev = 1'b0;
    for (int i = 0; i < 700; i++) begin
      drv_dir  = 1'b0;
      drv_step = (i == 0 || i == 10 || i == 20);
      tick(1);
      if (sm_step === 1'b1 && prev === 1'b0) begin
        rises++;
        if (first < 0) first = i; else if (second < 0) second = i;
      end
      prev = sm_step;
    end
    drv_step = 1'b0;
    n_checks++; if (rises != 2) begin n_fail++; $display("FAIL burst_pulses: got %0d want 2", rises); end
    n_checks++; if (overrun_cnt !== 16'd1) begin n_fail++; $display("FAIL burst_overrun: got %0d want 1", overrun_cnt); end
    n_checks++; if (second - first < 201) begin n_fail++; $display("FAIL burst_spacing: got %0d want >=201", second - first); end
    n_checks++; if (position !== -8'sd2) begin n_fail++; $display("FAIL burst_pos: got %0d want -2", position); end
  endtask

  task automatic test_limit();
    int t;
    int lh;
    int lh_at;
    int hi;
    wait_idle(400, t);
    lim_fwd = 1'b1;
    lh = 0; lh_at = -1; hi = 0;
    for (int i = 0; i < 300; i++) begin
      drv_dir  = 1'b1;
      drv_step = (i == 0);
      tick(1);
      if (limit_hit === 1'b1) begin lh++; if (lh_at < 0) lh_at = i; end
      if (sm_step === 1'b1) hi++;
    end
    drv_step = 1'b0;
    n_checks++; if (lh != 1) begin n_fail++; $display("FAIL limit_pulses: got %0d want 1", lh); end
    n_checks++; if (lh_at != 1) begin n_fail++; $display("FAIL limit_timing: got %0d want 1", lh_at); end
    n_checks++; if (hi != 0) begin n_fail++; $display("FAIL limit_no_step: got %0d high cycles want 0", hi); end
    n_checks++; if (sm_dir !== 1'b0) begin n_fail++; $display("FAIL limit_dir: got %b want 0", sm_dir); end
    n_checks++; if (position !== -8'sd2) begin n_fail++; $display("FAIL limit_pos: got %0d want -2", position); end
    pulse_step(1'b0);
    tick(1);
    n_checks++; if (sm_step !== 1'b1) begin n_fail++; $display("FAIL limit_rev_step: got %b want 1", sm_step); end
    wait_fall(300, t);
    n_checks++; if (position !== -8'sd3) begin n_fail++; $display("FAIL limit_rev_pos: got %0d want -3", position); end
    lim_fwd = 1'b0;
  endtask

  task automatic test_enable_drop();
    int t;
    int hi;
    int first;
    wait_idle(400, t);
    pulse_step(1'b0);
    tick(1);
    tick(24);
    pulse_step(1'b0);
    tick(24);
    n_checks++; if (sm_step !== 1'b1) begin n_fail++; $display("FAIL drop_mid_pulse: got %b want 1", sm_step); end
    drv_enable_SM = 1'b0;
    tick(1);
    n_checks++; if (sm_step !== 1'b0) begin n_fail++; $display("FAIL drop_step: got %b want 0", sm_step); end
    n_checks++; if (sm_ena !== 1'b0) begin n_fail++; $display("FAIL drop_ena: got %b want 0", sm_ena); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL drop_busy: got %b want 0", busy); end
    n_checks++; if (position !== -8'sd3) begin n_fail++; $display("FAIL drop_pos: got %0d want -3", position); end
    pulse_step(1'b0);
    tick(3);
    drv_enable_SM = 1'b1;
    hi = 0;
    for (int i = 0; i < 700; i++) begin
      tick(1);
      if (sm_step === 1'b1) hi++;
    end
    n_checks++; if (hi != 0) begin n_fail++; $display("FAIL drop_pend_clear: got %0d high cycles want 0", hi); end
    drv_enable_SM = 1'b0;
    tick(2);
    n_checks++; if (sm_ena !== 1'b0) begin n_fail++; $display("FAIL redrop_ena: got %b want 0", sm_ena); end
    drv_enable_SM = 1'b1;
    first = -1;
    for (int i = 1; i <= 700; i++) begin
      drv_dir  = 1'b0;
      drv_step = (i == 10);
      tick(1);
      if (sm_step === 1'b1 && first < 0) first = i;
    end
    drv_step = 1'b0;
    n_checks++; if (first != 502) begin n_fail++; $display("FAIL ena_setup_first_step: got %0d want 502", first); end
    n_checks++; if (position !== -8'sd4) begin n_fail++; $display("FAIL reenable_pos: got %0d want -4", position); end
  endtask

  task automatic test_wrap_clear();
    int t;
    int timeouts;
    wait_idle(400, t);
    pos_clr = 1'b1;
    tick(1);
    pos_clr = 1'b0;
    n_checks++; if (position !== 8'sd0) begin n_fail++; $display("FAIL pos_clr: got %0d want 0", position); end
    timeouts = 0;
    for (int k = 0; k < 127; k++) begin
      pulse_step(1'b1);
      wait_rise(400, t);
      if (t >= 400) timeouts++;
      wait_fall(200, t);
      if (t >= 200) timeouts++;
    end
    n_checks++; if (timeouts != 0) begin n_fail++; $display("FAIL wrap_timeouts: got %0d want 0", timeouts); end
    n_checks++; if (position !== 8'sd127) begin n_fail++; $display("FAIL pos_max: got %0d want 127", position); end
    pulse_step(1'b1);
    wait_rise(400, t);
    wait_fall(200, t);
    n_checks++; if (position !== 8'sh80) begin n_fail++; $display("FAIL pos_wrap: got %0d want -128", position); end
    pulse_step(1'b1);
    wait_rise(400, t);
    tick(99);
    pos_clr = 1'b1;
    tick(1);
    pos_clr = 1'b0;
    n_checks++; if (sm_step !== 1'b0) begin n_fail++; $display("FAIL clr_at_exit_step: got %b want 0", sm_step); end
    n_checks++; if (position !== 8'sd0) begin n_fail++; $display("FAIL clr_priority: got %0d want 0", position); end
  endtask

  task automatic test_reset_mid_pulse();
    int t;
    pulse_step(1'b1);
    wait_rise(400, t);
    tick(10);
    #2 rst = 1'b0;
    #1;
    n_checks++; if (sm_step !== 1'b0) begin n_fail++; $display("FAIL arst_step: got %b want 0", sm_step); end
    n_checks++; if (sm_ena !== 1'b0) begin n_fail++; $display("FAIL arst_ena: got %b want 0", sm_ena); end
    n_checks++; if (sm_dir !== 1'b0) begin n_fail++; $display("FAIL arst_dir: got %b want 0", sm_dir); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL arst_busy: got %b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_enable_single();
    test_reversal();
    test_back_to_back();
    test_limit();
    test_enable_drop();
    test_wrap_clear();
    test_reset_mid_pulse();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
